axis_frame_len_adjust: RTL

AXIS_FRAME_LEN_ADJUST -- requirements
Module: axis_frame_len_adjust

---
 rtl/axis_frame_len_adjust_pkg.sv | 26 ++
 rtl/axis_frame_len_outreg.sv | 62 ++++++
 rtl/axis_frame_len_adjust.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_len_adjust_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_len_adjust_pkg
// Description : Shared types for the AXI-Stream frame length adjuster.
//               - fla_state_t : adjuster state encoding (PASS / PAD / DROP)
//               - fla_beat_t  : one output beat (data, last, user)
// Config      : none in this file (see axis_frame_len_adjust for
//               AXIS_FRAME_LEN_TRUNC_TUSER_EN)
// Revision    : 1.0 - initial release
// ============================================================================
package axis_frame_len_adjust_pkg;

   typedef enum logic [1:0] {
      ST_PASS = 2'd0,
      ST_PAD  = 2'd1,
      ST_DROP = 2'd2
   } fla_state_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       user;
   } fla_beat_t;

endpackage : axis_frame_len_adjust_pkg
`default_nettype wire

// File: rtl/axis_frame_len_outreg.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_len_outreg
// Description : Single-entry AXI-Stream output holding register.
//               A beat offered on load_beat with load_valid is captured when
//               load_ready is high; the held beat stays stable until the
//               downstream accepts it.
// Ports       : clk, async_rst          - clock, async active-high reset
//               load_valid/load_beat    - beat to place in the register
//               load_ready              - register can take a beat this cycle
//               m_tdata/tvalid/tlast/tuser, m_tready - downstream stream
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_len_outreg
   import axis_frame_len_adjust_pkg::*;
(
   input  logic       clk,
   input  logic       async_rst,
   input  logic       load_valid,
   input  fla_beat_t  load_beat,
   output logic       load_ready,
   output logic [7:0] m_tdata,
   output logic       m_tvalid,
   output logic       m_tlast,
   output logic       m_tuser,
   input  logic       m_tready
);

   logic      tvalid_q, tvalid_d;
   fla_beat_t beat_q, beat_d;

   // Loadable when empty or when the held beat leaves this very cycle.
   assign load_ready = m_tready | ~tvalid_q;

   always_comb begin
      tvalid_d = tvalid_q;
      beat_d   = beat_q;
      if (load_valid && load_ready) begin
         tvalid_d = 1'b1;
         beat_d   = load_beat;
      end else if (m_tready) begin
         tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         tvalid_q <= 1'b0;
         beat_q   <= '0;
      end else begin
         tvalid_q <= tvalid_d;
         beat_q   <= beat_d;
      end
   end

   assign m_tvalid = tvalid_q;
   assign m_tdata  = beat_q.data;
   assign m_tlast  = beat_q.last;
   assign m_tuser  = beat_q.user;

endmodule : axis_frame_len_outreg
`default_nettype wire

// File: rtl/axis_frame_len_adjust.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_len_adjust
// Description : Forces AXI-Stream frames into [MIN_LEN, MAX_LEN] beats.
//               Short frames are padded with PAD_BYTE beats, long frames are
//               cut at MAX_LEN (tlast forced) and their remainder discarded.
// Ports       : clk, async_rst                  - clock, async active-high reset
//               input_axis_*                    - upstream stream
//               output_axis_*                   - adjusted stream (registered)
//               status_padded/status_truncated  - one pulse per adjusted frame
// Config      : `define AXIS_FRAME_LEN_TRUNC_TUSER_EN to force tuser=1 on the
//               last beat of a truncated frame; otherwise that beat keeps the
//               input tuser.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_len_adjust
   import axis_frame_len_adjust_pkg::*;
#(
   parameter int         MIN_LEN   = 4,
   parameter int         MAX_LEN   = 16,
   parameter int         LEN_WIDTH = 16,
   parameter logic [7:0] PAD_BYTE  = 8'h00
) (
   input  logic       clk,
   input  logic       async_rst,
   input  logic [7:0] input_axis_tdata,
   input  logic       input_axis_tvalid,
   input  logic       input_axis_tlast,
   input  logic       input_axis_tuser,
   output logic       input_axis_tready,
   output logic [7:0] output_axis_tdata,
   output logic       output_axis_tvalid,
   output logic       output_axis_tlast,
   output logic       output_axis_tuser,
   input  logic       output_axis_tready,
   output logic       status_padded,
   output logic       status_truncated
);

   localparam logic [LEN_WIDTH-1:0] C_MIN_LEN = LEN_WIDTH'(MIN_LEN);
   localparam logic [LEN_WIDTH-1:0] C_MAX_LEN = LEN_WIDTH'(MAX_LEN);

   fla_state_t           state_q, state_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic                 user_cap_q, user_cap_d;
   logic                 padded_q, padded_d;
   logic                 trunc_q, trunc_d;
   logic                 rdy_en_q, rdy_en_d;

   logic                 w_load_ready;
   logic                 w_load_valid;
   fla_beat_t            w_load_beat;
   logic                 w_in_ready;
   logic                 w_in_fire;
   logic [LEN_WIDTH-1:0] w_cnt_inc;
   logic                 w_trunc_user;

`ifdef AXIS_FRAME_LEN_TRUNC_TUSER_EN
   assign w_trunc_user = 1'b1;
`else
   assign w_trunc_user = input_axis_tuser;
`endif

   // rdy_en_q holds tready low while reset is applied and for the first
   // cycle after release, so upstream never sees a combinational ready
   // derived from an empty register during reset.
   always_comb begin
      w_in_ready = 1'b0;
      case (state_q)
         ST_PASS: w_in_ready = rdy_en_q & w_load_ready;
         ST_DROP: w_in_ready = rdy_en_q;
         default: w_in_ready = 1'b0;
      endcase
   end

   assign input_axis_tready = w_in_ready;
   assign w_in_fire         = input_axis_tvalid & w_in_ready;
   assign w_cnt_inc         = cnt_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      user_cap_d   = user_cap_q;
      padded_d     = 1'b0;
      trunc_d      = 1'b0;
      rdy_en_d     = 1'b1;
      w_load_valid = 1'b0;
      w_load_beat  = '{data: input_axis_tdata,
                        last: input_axis_tlast,
                        user: input_axis_tuser};

      case (state_q)
         ST_PASS: begin
            if (w_in_fire) begin
               w_load_valid = 1'b1;
               if (input_axis_tlast && (w_cnt_inc < C_MIN_LEN)) begin
                  // Short frame: tlast and tuser move to the final pad beat.
                  w_load_beat.last = 1'b0;
                  w_load_beat.user = 1'b0;
                  user_cap_d       = input_axis_tuser;
                  cnt_d            = w_cnt_inc;
                  state_d          = ST_PAD;
               end else if (!input_axis_tlast && (w_cnt_inc == C_MAX_LEN)) begin
                  w_load_beat.last = 1'b1;
                  w_load_beat.user = w_trunc_user;
                  trunc_d          = 1'b1;
                  cnt_d            = '0;
                  state_d          = ST_DROP;
               end else if (input_axis_tlast) begin
                  cnt_d = '0;
               end else begin
                  cnt_d = w_cnt_inc;
               end
            end
         end

         ST_PAD: begin
            if (w_load_ready) begin
               w_load_valid = 1'b1;
               w_load_beat  = '{data: PAD_BYTE, last: 1'b0, user: 1'b0};
               if (w_cnt_inc == C_MIN_LEN) begin
                  w_load_beat.last = 1'b1;
                  w_load_beat.user = user_cap_q;
                  padded_d         = 1'b1;
                  cnt_d            = '0;
                  state_d          = ST_PASS;
               end else begin
                  cnt_d = w_cnt_inc;
               end
            end
         end

         ST_DROP: begin
            // Remainder of an over-long frame is consumed and discarded.
            if (w_in_fire && input_axis_tlast) begin
               cnt_d   = '0;
               state_d = ST_PASS;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = ST_PASS;
         end
      endcase
   end

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         state_q    <= ST_PASS;
         cnt_q      <= '0;
         user_cap_q <= 1'b0;
         padded_q   <= 1'b0;
         trunc_q    <= 1'b0;
         rdy_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         user_cap_q <= user_cap_d;
         padded_q   <= padded_d;
         trunc_q    <= trunc_d;
         rdy_en_q   <= rdy_en_d;
      end
   end

   assign status_padded    = padded_q;
   assign status_truncated = trunc_q;

   axis_frame_len_outreg u_outreg (
      .clk        (clk),
      .async_rst  (async_rst),
      .load_valid (w_load_valid),
      .load_beat  (w_load_beat),
      .load_ready (w_load_ready),
      .m_tdata    (output_axis_tdata),
      .m_tvalid   (output_axis_tvalid),
      .m_tlast    (output_axis_tlast),
      .m_tuser    (output_axis_tuser),
      .m_tready   (output_axis_tready)
   );

endmodule : axis_frame_len_adjust
`default_nettype wire
